// File: rtl/spi_byte_master.sv
// Purpose: IO-mapped byte-wide SPI master (mode 0, MSB first) for the configuration flash.
// Latency: busy is high for exactly 16*CLKDIV clk cycles, starting the cycle after wr.
// Backpressure: wr while busy is dropped (software polls busy); rd clears valid; cs_wr is always accepted.
// Optional build macro SPI_MISO_SYNC_EN: routes miso through a 2-flop synchronizer and needs CLKDIV >= 3.
module spi_byte_master #(
    parameter int unsigned CLKDIV = 2,
    parameter int unsigned DIVW   = 8
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       wr,
    input  logic       rd,
    input  logic       cs_wr,
    input  logic       cs_wd,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       valid,
    output logic       sck,
    output logic       mosi,
    output logic       csn,
    input  logic       miso
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    // Reload value of the half-period counter; a phase ends when it reads zero.
    localparam logic [DIVW-1:0] DIV_LOAD = DIVW'(CLKDIV - 1);

    // Reject divider values that cannot be represented or make no sense.
    generate
        if (CLKDIV < 1 || CLKDIV > 255 || CLKDIV > (2 ** DIVW) - 1) begin : g_bad_clkdiv
            $error("spi_byte_master: CLKDIV out of range for DIVW");
        end
    endgenerate

    logic miso_s;

`ifdef SPI_MISO_SYNC_EN
    // The synchronized sample is taken two clk cycles into HIGH, so HIGH must
    // outlast that point by at least one cycle.
    localparam logic [DIVW-1:0] DIV_SAMPLE = DIVW'(CLKDIV - 2);

    generate
        if (CLKDIV < 3) begin : g_sync_needs_div3
            $error("spi_byte_master: SPI_MISO_SYNC_EN requires CLKDIV >= 3");
        end
    endgenerate

    logic [1:0] miso_sync;

    // Two-flop synchronizer on the asynchronous flash data line.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            miso_sync <= 2'b00;
        end else begin
            miso_sync <= {miso_sync[0], miso};
        end
    end

    assign miso_s = miso_sync[1];
`else
    assign miso_s = miso;
`endif

    state_t          state_q, state_nxt;
    logic [DIVW-1:0] div_q, div_nxt;
    logic [2:0]      bit_q, bit_nxt;
    logic [7:0]      shift_q, shift_nxt;
    logic [7:0]      rx_nxt;
    logic            busy_nxt, valid_nxt, sck_nxt, mosi_nxt, csn_nxt;

    // State and output registers; reset aborts any transfer without touching rx_data beyond clearing it.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            rx_data <= 8'h00;
            busy    <= 1'b0;
            valid   <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            csn     <= 1'b1;
        end else begin
            state_q <= state_nxt;
            div_q   <= div_nxt;
            bit_q   <= bit_nxt;
            shift_q <= shift_nxt;
            rx_data <= rx_nxt;
            busy    <= busy_nxt;
            valid   <= valid_nxt;
            sck     <= sck_nxt;
            mosi    <= mosi_nxt;
            csn     <= csn_nxt;
        end
    end

    // Next-state logic: half-period divider, bit sequencing, CS and valid handshake.
    always_comb begin
        state_nxt = state_q;
        div_nxt   = div_q;
        bit_nxt   = bit_q;
        shift_nxt = shift_q;
        rx_nxt    = rx_data;
        busy_nxt  = busy;
        valid_nxt = valid;
        sck_nxt   = sck;
        mosi_nxt  = mosi;
        csn_nxt   = csn;

        // Read clears valid; a completion later in this block overrides it.
        if (rd) begin
            valid_nxt = 1'b0;
        end

        // Chip select is software-owned and honoured in every state.
        if (cs_wr) begin
            csn_nxt = ~cs_wd;
        end

        case (state_q)
            IDLE: begin
                if (wr) begin
                    shift_nxt = tx_data;
                    mosi_nxt  = tx_data[7];
                    bit_nxt   = 3'd7;
                    div_nxt   = DIV_LOAD;
                    busy_nxt  = 1'b1;
                    state_nxt = LOW;
                end
            end

            LOW: begin
                if (div_q == '0) begin
                    sck_nxt   = 1'b1;
                    div_nxt   = DIV_LOAD;
                    state_nxt = HIGH;
`ifndef SPI_MISO_SYNC_EN
                    // Sample on the same edge that raises sck.
                    shift_nxt = {shift_q[6:0], miso_s};
`endif
                end else begin
                    div_nxt = div_q - DIVW'(1);
                end
            end

            HIGH: begin
                if (div_q == '0) begin
                    sck_nxt = 1'b0;
                    div_nxt = DIV_LOAD;
                    if (bit_q != 3'd0) begin
                        // shift_q[7] already holds the next bit after the sample shift.
                        bit_nxt   = bit_q - 3'd1;
                        mosi_nxt  = shift_q[7];
                        state_nxt = LOW;
                    end else begin
                        rx_nxt    = shift_q;
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end else begin
                    div_nxt = div_q - DIVW'(1);
`ifdef SPI_MISO_SYNC_EN
                    // Synchronized miso reflects the post-rise line two cycles into HIGH.
                    if (div_q == DIV_SAMPLE) begin
                        shift_nxt = {shift_q[6:0], miso_s};
                    end
`endif
                end
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                sck_nxt   = 1'b0;
            end
        endcase
    end

endmodule
